// File: rtl/spi_mailbox_bridge.sv
// Multi-port SPI slave bridge: NUM_PORTS masters share a byte mailbox and an
// arbitrated serial-RAM pass-through, with doorbell interrupts between ports.
module spi_mailbox_bridge #(
  parameter  int NUM_PORTS = 2,
  parameter  int DEPTH     = 16,
  localparam int OWNER_W   = $clog2(NUM_PORTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] spi_nss,
  input  logic [NUM_PORTS-1:0] spi_sck,
  input  logic [NUM_PORTS-1:0] spi_mosi,
  output logic [NUM_PORTS-1:0] spi_miso,
  output logic [NUM_PORTS-1:0] irq,
  output logic                 ram_nss,
  output logic                 ram_sck,
  output logic                 ram_mosi,
  input  logic                 ram_miso,
  output logic [OWNER_W-1:0]   bus_owner
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [OWNER_W-1:0] NONE = OWNER_W'(NUM_PORTS);

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WRITE, READ, RAM, DONE} state_t;

  logic [NUM_PORTS-1:0] nss_q1, nss_q2, sck_q1, sck_q2, sck_q3, mosi_q1, mosi_q2;
  logic [NUM_PORTS-1:0] rise, fall;
  logic [NUM_PORTS-1:0] seen_high, byte_vld, is_read, stat_mode, ram_armed;
  logic [2:0]           cnt [NUM_PORTS];
  logic [7:0]           sr  [NUM_PORTS];
  logic [7:0]           rx  [NUM_PORTS];
  logic [7:0]           tx  [NUM_PORTS];
  logic [AW-1:0]        ptr [NUM_PORTS];
  logic [7:0]           mbox [DEPTH];
  state_t               state    [NUM_PORTS];
  state_t               state_nx [NUM_PORTS];

  logic [NUM_PORTS-1:0] we, req, rel, st_clr, tx_load, ptr_load, ptr_inc;
  logic [7:0]           tx_val [NUM_PORTS];
  logic [OWNER_W-1:0]   owner_nx;
  logic [NUM_PORTS-1:0] irq_nx;

  // byte_vld is a one-clk strobe carrying rx; every consumer acts on it that
  // same clk, so there is no back-pressure path.
  assign rise = sck_q2 & ~sck_q3;
  assign fall = ~sck_q2 & sck_q3;

  // nss sync resets low so a master still selected across reset looks busy
  // until it deasserts (seen_high gates the restart).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nss_q1  <= '0;
      nss_q2  <= '0;
      sck_q1  <= '0;
      sck_q2  <= '0;
      sck_q3  <= '0;
      mosi_q1 <= '0;
      mosi_q2 <= '0;
    end else begin
      nss_q1  <= spi_nss;
      nss_q2  <= nss_q1;
      sck_q1  <= spi_sck;
      sck_q2  <= sck_q1;
      sck_q3  <= sck_q2;
      mosi_q1 <= spi_mosi;
      mosi_q2 <= mosi_q1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state[p] <= IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) state[p] <= state_nx[p];
    end
  end

  always_comb begin
    logic [AW-1:0] nptr;
    nptr     = '0;
    we       = '0;
    req      = '0;
    rel      = '0;
    st_clr   = '0;
    tx_load  = '0;
    ptr_load = '0;
    ptr_inc  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_nx[p] = state[p];
      tx_val[p]   = tx[p];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      nptr = ptr[p] + AW'(1);
      if (nss_q2[p]) begin
        state_nx[p] = IDLE;
      end else begin
        case (state[p])
          IDLE: if (seen_high[p]) state_nx[p] = OPCODE;
          OPCODE: if (byte_vld[p]) begin
            case (rx[p])
              8'h01, 8'h02: state_nx[p] = ADDR;
              8'h03:        state_nx[p] = RAM;
              8'h04: begin
                state_nx[p] = READ;
                tx_load[p]  = 1'b1;
                tx_val[p]   = {3'b000, irq[p], bus_owner == OWNER_W'(p), 3'(bus_owner)};
              end
              8'h05: begin
                req[p]      = 1'b1;
                state_nx[p] = DONE;
              end
              8'h06: begin
                rel[p]      = 1'b1;
                state_nx[p] = DONE;
              end
              default: state_nx[p] = DONE;
            endcase
          end
          ADDR: if (byte_vld[p]) begin
            ptr_load[p] = 1'b1;
            if (is_read[p]) begin
              state_nx[p] = READ;
              tx_load[p]  = 1'b1;
              tx_val[p]   = mbox[rx[p][AW-1:0]];
            end else begin
              state_nx[p] = WRITE;
            end
          end
          WRITE: if (byte_vld[p]) begin
            we[p]      = 1'b1;
            ptr_inc[p] = 1'b1;
          end
          READ: if (byte_vld[p]) begin
            if (stat_mode[p]) begin
              st_clr[p]   = 1'b1;
              state_nx[p] = DONE;
            end else begin
              ptr_inc[p] = 1'b1;
              tx_load[p] = 1'b1;
              tx_val[p]  = mbox[nptr];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The fall right after a byte's 8th rise (cnt back at 0) must not shift:
  // the freshly loaded bit 0 has to be on MISO for the next byte's first rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_high <= '0;
      byte_vld  <= '0;
      is_read   <= '0;
      stat_mode <= '0;
      ram_armed <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt[p] <= '0;
        sr[p]  <= '0;
        rx[p]  <= '0;
        tx[p]  <= '0;
        ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (nss_q2[p]) seen_high[p] <= 1'b1;
        if (nss_q2[p] || !seen_high[p]) begin
          cnt[p]       <= '0;
          byte_vld[p]  <= 1'b0;
          ram_armed[p] <= 1'b0;
        end else begin
          byte_vld[p] <= rise[p] && (cnt[p] == 3'd7);
          if (rise[p]) begin
            sr[p]  <= {mosi_q2[p], sr[p][7:1]};
            cnt[p] <= cnt[p] + 3'd1;
            if (cnt[p] == 3'd7) rx[p] <= {mosi_q2[p], sr[p][7:1]};
          end
          if (state[p] == RAM && fall[p]) ram_armed[p] <= 1'b1;
        end
        if (tx_load[p]) tx[p] <= tx_val[p];
        else if (fall[p] && cnt[p] != 3'd0) tx[p] <= {1'b1, tx[p][7:1]};
        if (ptr_load[p]) ptr[p] <= rx[p][AW-1:0];
        else if (ptr_inc[p]) ptr[p] <= ptr[p] + AW'(1);
        if (state[p] == OPCODE && byte_vld[p]) begin
          is_read[p]   <= (rx[p] == 8'h02);
          stat_mode[p] <= (rx[p] == 8'h04);
        end
      end
    end
  end

  // Descending loop: the lowest port index writes last and wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mbox[i] <= '0;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (we[p]) mbox[ptr[p]] <= rx[p];
      end
    end
  end

  always_comb begin
    owner_nx = bus_owner;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (req[p] && bus_owner == NONE) owner_nx = OWNER_W'(p);
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rel[p] && bus_owner == OWNER_W'(p)) owner_nx = NONE;
    end
    irq_nx = irq & ~st_clr;
    for (int w = 0; w < NUM_PORTS; w++) begin
      if (we[w] && ptr[w] == AW'(DEPTH - 1)) irq_nx = irq_nx | ~(NUM_PORTS'(1) << w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_owner <= NONE;
      irq       <= '0;
    end else begin
      bus_owner <= owner_nx;
      irq       <= irq_nx;
    end
  end

  // RAM pins follow the owner's raw pins; SCK stays gated until the opcode
  // byte's last fall so the RAM never sees a partial first clock.
  always_comb begin
    ram_nss  = 1'b1;
    ram_sck  = 1'b0;
    ram_mosi = 1'b0;
    spi_miso = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state[p] == RAM && bus_owner == OWNER_W'(p)) begin
        ram_nss  = spi_nss[p];
        ram_sck  = spi_sck[p] & ram_armed[p];
        ram_mosi = spi_mosi[p];
      end
      if (spi_nss[p]) begin
        spi_miso[p] = 1'b0;
      end else begin
        case (state[p])
          IDLE:    spi_miso[p] = 1'b0;
          READ:    spi_miso[p] = tx[p][0];
          RAM:     spi_miso[p] = (bus_owner == OWNER_W'(p)) ? ram_miso : 1'b1;
          default: spi_miso[p] = sr[p][0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mailbox_bridge.sv
// Directed bench for spi_mailbox_bridge: two SPI masters, a looped-back RAM
// model (ram_miso = ~ram_mosi), and a read-data expected queue.
module tb_spi_mailbox_bridge;

  localparam int NP = 2;
  localparam int DEPTH = 16;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] spi_nss, spi_sck, spi_mosi, spi_miso, irq;
  logic          ram_nss, ram_sck, ram_mosi, ram_miso;
  logic [OW-1:0] bus_owner;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rd0, rd1;
  int          ram_pulses = 0;
  int          ram_falls = 0;
  logic [15:0] ram_cap;
  int          pulses_at, falls_at;

  // clock / reset block
  always #5 clk = ~clk;

  assign ram_miso = ~ram_mosi;

  spi_mailbox_bridge #(.NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .spi_nss(spi_nss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .irq(irq),
    .ram_nss(ram_nss), .ram_sck(ram_sck), .ram_mosi(ram_mosi), .ram_miso(ram_miso),
    .bus_owner(bus_owner)
  );

  always @(posedge ram_sck) begin
    ram_pulses <= ram_pulses + 1;
    ram_cap    <= {ram_mosi, ram_cap[15:1]};
  end

  always @(negedge ram_nss) ram_falls <= ram_falls + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [7:0] got);
    logic [7:0] e;
    e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start(input logic [NP-1:0] mask);
    spi_nss = spi_nss & ~mask;
    wait_clk(8);
  endtask

  task automatic frame_stop();
    spi_nss  = '1;
    spi_sck  = '0;
    spi_mosi = '0;
    wait_clk(8);
  endtask

  // Mode 0, LSB first: data set while SCK low, MISO sampled just before rise.
  task automatic xfer(input logic [NP-1:0] mask, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < 8; i++) begin
      if (mask[0]) spi_mosi[0] = b0[i];
      if (mask[1]) spi_mosi[1] = b1[i];
      wait_clk(4);
      rd0[i] = spi_miso[0];
      rd1[i] = spi_miso[1];
      spi_sck = spi_sck | mask;
      wait_clk(8);
      spi_sck = spi_sck & ~mask;
      wait_clk(4);
    end
  endtask

  task automatic send(input int port, input logic [7:0] b);
    xfer(NP'(1) << port, b, b);
  endtask

  task automatic cmd(input int port, input logic [7:0] op);
    frame_start(NP'(1) << port);
    send(port, op);
    frame_stop();
  endtask

  initial begin
    reset    = 1'b1;
    spi_nss  = '1;
    spi_sck  = '0;
    spi_mosi = '0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    check("rst_owner", bus_owner, 2);
    check("rst_irq", irq, 0);
    check("rst_ram_nss", ram_nss, 1);
    check("rst_ram_sck", ram_sck, 0);
    check("rst_ram_mosi", ram_mosi, 0);
    check("rst_miso", spi_miso, 0);

    // mailbox round trip
    frame_start(2'b01);
    send(0, 8'h01); send(0, 8'h03); send(0, 8'hAA); send(0, 8'h55);
    frame_stop();
    check("rt_no_irq", irq, 0);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    frame_start(2'b10);
    send(1, 8'h02); send(1, 8'h03);
    send(1, 8'h00); rd_check("rt_rd0", rd1);
    send(1, 8'h00); rd_check("rt_rd1", rd1);
    frame_stop();

    // address wrap and doorbell
    frame_start(2'b01);
    send(0, 8'h01); send(0, 8'h0F); send(0, 8'h11); send(0, 8'h22);
    frame_stop();
    check("wrap_irq", irq, 2'b10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    frame_start(2'b10);
    send(1, 8'h02); send(1, 8'h0F);
    send(1, 8'h00); rd_check("wrap_rd15", rd1);
    send(1, 8'h00); rd_check("wrap_rd0", rd1);
    frame_stop();
    frame_start(2'b10);
    send(1, 8'h04); send(1, 8'h00);
    frame_stop();
    check("stat_irq_set", rd1, 8'h12);
    check("stat_irq_cleared", irq, 0);
    frame_start(2'b10);
    send(1, 8'h04); send(1, 8'h00);
    frame_stop();
    check("stat_second", rd1, 8'h02);

    // arbitration
    cmd(1, 8'h05); check("arb_req1", bus_owner, 1);
    cmd(0, 8'h05); check("arb_req0_busy", bus_owner, 1);
    cmd(0, 8'h06); check("arb_rel0_nonowner", bus_owner, 1);
    cmd(1, 8'h06); check("arb_rel1", bus_owner, 2);

    // RAM pass-through
    cmd(0, 8'h05); check("ram_req0", bus_owner, 0);
    pulses_at = ram_pulses;
    falls_at  = ram_falls;
    frame_start(2'b01);
    send(0, 8'h03);
    send(0, 8'hA5); check("ram_miso_b0", rd0, 8'h5A);
    send(0, 8'h3C); check("ram_miso_b1", rd0, 8'hC3);
    check("ram_nss_active", ram_nss, 0);
    frame_stop();
    check("ram_nss_after", ram_nss, 1);
    check("ram_pulses", ram_pulses - pulses_at, 16);
    check("ram_mosi_cap", ram_cap, 16'h3CA5);
    check("ram_nss_falls", ram_falls - falls_at, 1);
    pulses_at = ram_pulses;
    frame_start(2'b10);
    send(1, 8'h03);
    send(1, 8'h00); check("ram_nonowner_ff", rd1, 8'hFF);
    check("ram_nonowner_idle", ram_nss, 1);
    frame_stop();
    check("ram_nonowner_pulses", ram_pulses - pulses_at, 0);
    cmd(0, 8'h06); check("ram_rel0", bus_owner, 2);

    // simultaneous request and same-entry write
    frame_start(2'b11);
    xfer(2'b11, 8'h05, 8'h05);
    frame_stop();
    check("sim_req_owner", bus_owner, 0);
    frame_start(2'b11);
    xfer(2'b11, 8'h01, 8'h01);
    xfer(2'b11, 8'h05, 8'h05);
    xfer(2'b11, 8'h77, 8'h88);
    frame_stop();
    check("sim_no_irq", irq, 0);
    exp_q.push_back(8'h77);
    frame_start(2'b10);
    send(1, 8'h02); send(1, 8'h05);
    send(1, 8'h00); rd_check("sim_wr_winner", rd1);
    frame_stop();

    // reset in the middle of a RAM access
    frame_start(2'b01);
    send(0, 8'h03);
    spi_mosi[0] = 1'b1;
    wait_clk(4);
    spi_sck[0] = 1'b1;
    wait_clk(8);
    spi_sck[0] = 1'b0;
    wait_clk(4);
    spi_sck[0] = 1'b1;
    wait_clk(2);
    check("pre_rst_ram_nss", ram_nss, 0);
    check("pre_rst_ram_sck", ram_sck, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ram_nss", ram_nss, 1);
    check("mid_rst_owner", bus_owner, 2);
    check("mid_rst_ram_sck", ram_sck, 0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    spi_sck[0] = 1'b0;
    wait_clk(8);
    spi_sck[0] = 1'b1;
    wait_clk(8);
    check("post_rst_hold_nss", ram_nss, 1);
    check("post_rst_hold_miso", spi_miso[0], 0);
    frame_stop();
    exp_q.push_back(8'h00);
    frame_start(2'b10);
    send(1, 8'h02); send(1, 8'h05);
    send(1, 8'h00); rd_check("post_rst_mbox", rd1);
    frame_stop();
    check("post_rst_irq", irq, 0);
    check("post_rst_owner", bus_owner, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mailbox_bridge.md
# spi_mailbox_bridge

Parametrised multi-port SPI slave that succeeds the two-port MCU/coprocessor core logic. It connects NUM_PORTS independent SPI masters to a shared byte mailbox and to a single serial RAM. Bus ownership is arbitrated explicitly, with doorbell interrupts between ports. All protocol logic runs on a system clock that oversamples the SPI pins; only the RAM pass-through path is combinational.

## Interface
- NUM_PORTS, 2: number of SPI slave ports (2..4).
- DEPTH, 16: mailbox entries, 8 bits each (power of two, 4..256).
- OWNER_W, derived: $clog2(NUM_PORTS+1).
- clk  in  1  system clock, must be ≥ 8× fastest SCK.
- reset  in  1  reset, asynchronous, active-high.
- spi_nss  in  NUM_PORTS  per-port chip select, active-low.
- spi_sck  in  NUM_PORTS  per-port SCK, SPI mode 0.
- spi_mosi  in  NUM_PORTS  per-port MOSI, bytes LSB-first.
- spi_miso  out  NUM_PORTS  per-port MISO.
- irq  out  NUM_PORTS  per-port doorbell interrupt, active-high level.
- ram_nss, ram_sck, ram_mosi  out  1 each  serial RAM bus.
- ram_miso  in  1  serial RAM data.
- bus_owner  out  OWNER_W  current RAM owner; NUM_PORTS = none.

## Operation
- Per port: 2-flop synchronizer on nss/sck/mosi, SCK rise/fall edge detect, 3-bit bit counter, 8-bit shift register, FSM.
- FSM states: IDLE, OPCODE, ADDR, WRITE, READ, RAM, DONE. nss high forces IDLE and clears the counter, from any state.
- nss falling → OPCODE. After the 8th bit, the opcode decodes:
  - 0x01 WRITE_MBOX → ADDR → WRITE.
  - 0x02 READ_MBOX → ADDR → READ.
  - 0x03 ACCESS_RAM → RAM.
  - 0x04 READ_STATUS.
  - 0x05 REQUEST_BUS.
  - 0x06 RELEASE_BUS.
  - Any other opcode → DONE (ignore until nss high).
- ADDR: the byte is taken modulo DEPTH as the pointer. WRITE stores each complete byte to mailbox[ptr]. READ shifts out mailbox[ptr], with the next byte fetched when the current byte completes. The pointer increments per byte and wraps DEPTH-1→0.
- READ_STATUS returns one byte: bits[2:0] = bus_owner (zero-extended), bit3 = this port owns the bus, bit4 = own irq. Returning status clears own irq after the byte completes; subsequent bytes → DONE.
- REQUEST_BUS: if owner = none, owner ← port. Otherwise no change. State → DONE.
- RELEASE_BUS: if owner = port, owner ← none. A non-owner release is ignored.
- Doorbell: writing mailbox[DEPTH-1] sets irq on every port except the writer.
- RAM state when port owns the bus: ram_nss/ram_sck/ram_mosi = raw port pins, and spi_miso = ram_miso.
- RAM state when port does not own the bus: RAM idle, spi_miso = 1 for all bits, and the access is dropped.
- RAM idle levels: ram_nss=1, ram_sck=0, ram_mosi=0.
- spi_miso is 0 while the port's nss is high. In OPCODE/ADDR/WRITE/DONE it echoes shift-register bit 0.
- Simultaneous events:
  - Same-cycle writes to one entry: lowest port index wins; the others are lost.
  - Same-cycle REQUEST_BUS: lowest index wins.
  - Doorbell set and status-clear on the same port in the same cycle: set wins.
- Owner nss rising mid-RAM access: ram_nss goes high combinationally. Ownership is retained.

## Timing
- Reset values:
  - all FSMs IDLE, counters 0, mailbox all 0x00;
  - owner = none, irq = 0, spi_miso = 0;
  - ram_nss=1, ram_sck=0, ram_mosi=0.
- Pin-to-internal latency: 2 clk sync + 1 clk edge detect.
- Bytes and opcodes are decoded on the clk after the 8th synchronized SCK rise. Mailbox writes commit on that same clk.
- MISO data changes on the clk after a detected SCK fall. The first read bit is valid before the 1st SCK rise of the data byte.
- RAM entry: ram_nss falls ≤ 4 clk after the 8th opcode SCK rise, so the 9th SCK is the RAM's first clock.
- irq asserts 1 clk after the doorbell write commit.
- bus_owner updates 1 clk after the opcode decode.
- Asynchronous reset mid-transfer aborts all transfers. The transfer restarts only after nss deasserts.

## Test plan
- Mailbox round trip: port0 writes 0x01,0x03,0xAA,0x55 → port1 reads 0x02,0x03 → MISO returns 0xAA,0x55. No irq.
- Address wrap with DEPTH=16: write opcode, addr 0x0F, bytes 0x11,0x22 → mailbox[15]=0x11, mailbox[0]=0x22. irq[1]=1 and irq[0]=0. Port1 READ_STATUS returns bit4=1, and the next status read returns bit4=0.
- Bus arbitration:
  - port1 REQUEST → bus_owner=1;
  - port0 REQUEST → still 1;
  - port0 RELEASE → still 1;
  - port1 RELEASE → owner = NUM_PORTS.
- RAM pass-through: port0 owns the bus, sends 0x03 followed by 16 SCKs → ram_sck shows exactly 16 pulses, ram_mosi matches, and spi_miso[0] follows ram_miso. A non-owner issuing 0x03 reads 0xFF and the RAM stays idle.
- Simultaneous REQUEST and same-address write from ports 0 and 1 aligned to the same clk → owner=0 and the mailbox holds port0's byte.
- Assert reset mid-RAM-access → ram_nss=1 and owner=none immediately, and the mailbox reads back 0x00.
